// File: rtl/counter_updown_mod.sv
// Up/down modulo counter with programmable step, runtime limit and wrap-or-saturate at range ends.
// One-cycle latency: cnt_out, tc and ovf all update on the edge that consumes the inputs; no backpressure.
module counter_updown_mod #(
   parameter int WIDTH    = 8,
   parameter int STEP_W   = 4,
   parameter int SATURATE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enab,
   input  logic              load,
   input  logic [WIDTH-1:0]  cnt_in,
   input  logic              up,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  max_val,
   input  logic              clr_ovf,
   output logic [WIDTH-1:0]  cnt_out,
   output logic              tc,
   output logic              ovf
);

   logic [WIDTH-1:0] r_cnt;
   logic             r_tc;
   logic             r_ovf;

   logic [WIDTH:0]   w_cnt_x;
   logic [WIDTH:0]   w_max_x;
   logic [WIDTH:0]   w_lim_x;
   logic [WIDTH:0]   w_step_x;
   logic [WIDTH:0]   w_eff_x;
   logic [WIDTH:0]   w_sum_x;
   logic [WIDTH:0]   w_next_x;
   logic [WIDTH-1:0] w_load_val;
   logic             w_event;

   // Everything is widened by one bit so sum and max_val+1 never truncate.
   assign w_cnt_x  = {1'b0, r_cnt};
   assign w_max_x  = {1'b0, max_val};
   assign w_lim_x  = w_max_x + {{WIDTH{1'b0}}, 1'b1};
   assign w_step_x = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
   assign w_eff_x  = (w_step_x > w_max_x) ? w_max_x : w_step_x;
   assign w_sum_x  = w_cnt_x + w_eff_x;

   assign w_load_val = (cnt_in > max_val) ? max_val : cnt_in;

   always_comb begin
      w_next_x = w_cnt_x;
      w_event  = 1'b0;
      if (w_cnt_x > w_max_x) begin
         // max_val was lowered below the current count
         w_event  = 1'b1;
         w_next_x = (SATURATE != 0) ? w_max_x : '0;
      end else if (up) begin
         if (w_sum_x > w_max_x) begin
            w_event  = 1'b1;
            w_next_x = (SATURATE != 0) ? w_max_x : (w_sum_x - w_lim_x);
         end else begin
            w_next_x = w_sum_x;
         end
      end else begin
         if (w_cnt_x >= w_eff_x) begin
            w_next_x = w_cnt_x - w_eff_x;
         end else begin
            w_event  = 1'b1;
            w_next_x = (SATURATE != 0) ? '0 : (w_cnt_x + w_lim_x - w_eff_x);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_tc  <= 1'b0;
         r_ovf <= 1'b0;
      end else begin
         if (load) begin
            r_cnt <= w_load_val;
            r_tc  <= 1'b0;
         end else if (enab) begin
            r_cnt <= w_next_x[WIDTH-1:0];
            r_tc  <= w_event;
         end else begin
            r_tc  <= 1'b0;
         end
         // A new event outranks a simultaneous clear.
         if (!load && enab && w_event) begin
            r_ovf <= 1'b1;
         end else if (clr_ovf) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign cnt_out = r_cnt;
   assign tc      = r_tc;
   assign ovf     = r_ovf;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Drives a wrapping and a saturating counter side by side from one stimulus stream
// and compares both against an arithmetic model of the counting rules.
module tb_counter_updown_mod;

   localparam int WIDTH  = 8;
   localparam int STEP_W = 4;

   logic              clk = 1'b0;
   logic              rst, enab, load, up, clr_ovf;
   logic [WIDTH-1:0]  cnt_in, max_val;
   logic [STEP_W-1:0] step;

   logic [WIDTH-1:0]  w_cnt, s_cnt;
   logic              w_tc, s_tc, w_ovf, s_ovf;

   int n_chk = 0;
   int n_err = 0;

   // index 0 = wrap, 1 = saturate
   int m_cnt [2];
   int m_tc  [2];
   int m_ovf [2];

   always #5 clk = ~clk;

   counter_updown_mod #(.WIDTH(WIDTH), .STEP_W(STEP_W), .SATURATE(0)) u_wrap (
      .clk(clk), .rst(rst), .enab(enab), .load(load), .cnt_in(cnt_in), .up(up),
      .step(step), .max_val(max_val), .clr_ovf(clr_ovf),
      .cnt_out(w_cnt), .tc(w_tc), .ovf(w_ovf));

   counter_updown_mod #(.WIDTH(WIDTH), .STEP_W(STEP_W), .SATURATE(1)) u_sat (
      .clk(clk), .rst(rst), .enab(enab), .load(load), .cnt_in(cnt_in), .up(up),
      .step(step), .max_val(max_val), .clr_ovf(clr_ovf),
      .cnt_out(s_cnt), .tc(s_tc), .ovf(s_ovf));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Counting in the range 0..max is arithmetic modulo max+1; an event is any
   // attempt to leave the range.
   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         int  mx, c, e, nx;
         bit  ev;
         mx = int'(max_val);
         c  = m_cnt[k];
         e  = (int'(step) > mx) ? mx : int'(step);
         ev = 1'b0;
         nx = c;
         if (rst) begin
            m_cnt[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
         end else begin
            if (load) begin
               nx = (int'(cnt_in) > mx) ? mx : int'(cnt_in);
            end else if (enab) begin
               if (c > mx) begin
                  ev = 1'b1;
                  nx = (k == 1) ? mx : 0;
               end else if (up) begin
                  ev = (c + e > mx);
                  nx = (ev && k == 1) ? mx : (c + e) % (mx + 1);
               end else begin
                  ev = (c < e);
                  nx = (ev && k == 1) ? 0 : (c - e + mx + 1) % (mx + 1);
               end
            end
            m_cnt[k] = nx;
            m_tc[k]  = ev ? 1 : 0;
            m_ovf[k] = ev ? 1 : (clr_ovf ? 0 : m_ovf[k]);
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("wrap_cnt", 32'(w_cnt), m_cnt[0]);
      chk("wrap_tc",  32'(w_tc),  m_tc[0]);
      chk("wrap_ovf", 32'(w_ovf), m_ovf[0]);
      chk("sat_cnt",  32'(s_cnt), m_cnt[1]);
      chk("sat_tc",   32'(s_tc),  m_tc[1]);
      chk("sat_ovf",  32'(s_ovf), m_ovf[1]);
   endtask

   task automatic drive(input logic r, input logic l, input logic en, input logic [WIDTH-1:0] ci,
                        input logic u, input logic [STEP_W-1:0] st, input logic [WIDTH-1:0] mx,
                        input logic c);
      rst = r; load = l; enab = en; cnt_in = ci; up = u; step = st; max_val = mx; clr_ovf = c;
   endtask

   initial begin
      int wu_cnt [5] = '{0, 3, 6, 9, 2};
      int wu_tc  [5] = '{1, 0, 0, 0, 1};
      int wd_cnt [3] = '{7, 3, 9};
      int wd_tc  [3] = '{1, 0, 1};

      m_cnt = '{0, 0}; m_tc = '{0, 0}; m_ovf = '{0, 0};
      drive(1, 1, 1, 8'h33, 1, 4'd1, 8'hFF, 0);
      @(negedge clk);

      // reset beats load and enable
      cyc();
      chk("rst_cnt", 32'(w_cnt), 0);
      chk("rst_ovf", 32'(w_ovf), 0);
      drive(0, 1, 1, 8'h33, 1, 4'd1, 8'hFF, 0);
      cyc();
      chk("load_enab_cnt", 32'(w_cnt), 32'h33);
      chk("load_enab_tc", 32'(w_tc), 0);

      // wrap up
      drive(0, 1, 0, 8'd7, 1, 4'd3, 8'd9, 0);
      cyc();
      drive(0, 0, 1, 8'd0, 1, 4'd3, 8'd9, 0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("wrap_up_cnt", 32'(w_cnt), wu_cnt[i]);
         chk("wrap_up_tc", 32'(w_tc), wu_tc[i]);
      end
      chk("wrap_up_ovf", 32'(w_ovf), 1);

      // wrap down, then clear ovf on an idle cycle
      drive(0, 1, 0, 8'd1, 0, 4'd4, 8'd9, 0);
      cyc();
      drive(0, 0, 1, 8'd0, 0, 4'd4, 8'd9, 0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("wrap_dn_cnt", 32'(w_cnt), wd_cnt[i]);
         chk("wrap_dn_tc", 32'(w_tc), wd_tc[i]);
      end
      drive(0, 0, 0, 8'd0, 0, 4'd4, 8'd9, 1);
      cyc();
      chk("clr_ovf", 32'(w_ovf), 0);

      // saturate: pinned at the top keeps firing tc
      drive(0, 1, 0, 8'd198, 1, 4'd5, 8'd200, 0);
      cyc();
      drive(0, 0, 1, 8'd0, 1, 4'd5, 8'd200, 0);
      cyc();
      chk("sat_up_cnt0", 32'(s_cnt), 200);
      chk("sat_up_tc0", 32'(s_tc), 1);
      cyc();
      chk("sat_up_cnt1", 32'(s_cnt), 200);
      chk("sat_up_tc1", 32'(s_tc), 1);
      drive(0, 1, 0, 8'd10, 0, 4'd15, 8'd200, 0);
      cyc();
      drive(0, 0, 1, 8'd0, 0, 4'd15, 8'd200, 0);
      cyc();
      chk("sat_dn_cnt", 32'(s_cnt), 0);
      chk("sat_dn_tc", 32'(s_tc), 1);

      // clamped load, clamped step, lowered limit
      drive(0, 1, 0, 8'd9, 1, 4'd12, 8'd5, 0);
      cyc();
      chk("clamp_load", 32'(w_cnt), 5);
      drive(0, 0, 1, 8'd0, 1, 4'd12, 8'd5, 0);
      cyc();
      chk("clamp_step", 32'(w_cnt), 4);
      drive(0, 0, 1, 8'd0, 1, 4'd1, 8'd2, 0);
      cyc();
      chk("lower_max_cnt", 32'(w_cnt), 0);
      chk("lower_max_tc", 32'(w_tc), 1);

      // event and clear on the same edge
      drive(0, 0, 0, 8'd0, 1, 4'd2, 8'd2, 1);
      cyc();
      drive(0, 0, 1, 8'd0, 1, 4'd2, 8'd2, 0);
      cyc();
      drive(0, 0, 1, 8'd0, 1, 4'd2, 8'd2, 1);
      cyc();
      chk("set_wins_ovf", 32'(w_ovf), 1);

      // zero step holds
      drive(0, 0, 1, 8'd0, 1, 4'd0, 8'd9, 0);
      cyc();
      chk("step0_cnt", 32'(w_cnt), 1);
      chk("step0_tc", 32'(w_tc), 0);

      // max_val = 0 pins the count at zero
      drive(0, 1, 0, 8'd0, 1, 4'd7, 8'd0, 0);
      cyc();
      drive(0, 0, 1, 8'd0, 1, 4'd7, 8'd0, 0);
      for (int i = 0; i < 10; i++) begin
         up = 1'($urandom_range(0, 1));
         cyc();
         chk("max0_cnt", 32'(w_cnt), 0);
         chk("max0_tc", 32'(w_tc), 0);
      end

      // random traffic, including mid-count reset and runtime limit changes
      for (int i = 0; i < 3000; i++) begin
         rst     = ($urandom_range(0, 99) < 2);
         load    = ($urandom_range(0, 99) < 10);
         enab    = ($urandom_range(0, 99) < 75);
         clr_ovf = ($urandom_range(0, 99) < 8);
         up      = 1'($urandom_range(0, 1));
         step    = STEP_W'($urandom);
         cnt_in  = WIDTH'($urandom);
         if ($urandom_range(0, 99) < 15) begin
            max_val = ($urandom_range(0, 1) == 1) ? WIDTH'($urandom_range(0, 12)) : WIDTH'($urandom);
         end
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
